// File: rtl/uart_rx_frm.sv
// uart_rx_frm: UART frame receiver (start, 8 data bits MSB first, even parity, stop).
// Optional feature macro: UART_RX_PARITY_CHK_EN enables the par_err check; when it is
// undefined the parity bit is still timed and sampled but discarded, and par_err stays 0.
module uart_rx_frm #(
   parameter int unsigned BAUD_DIV = 868,
   parameter int unsigned CNT_W    = 16
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_vld,
   output logic       par_err,
   output logic       frm_err,
   output logic       rx_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_BRK
   } state_t;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

   logic [1:0]       sync_q, sync_d;
   logic             rx_s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       sh_q, sh_d;
   logic [7:0]       data_q, data_d;
   logic             vld_q, vld_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_CHK_EN
   logic             par_q, par_d;
`endif

   assign rx_s    = sync_q[1];
   assign rx_data = data_q;
   assign rx_vld  = vld_q;
   assign par_err = perr_q;
   assign frm_err = ferr_q;
   assign rx_busy = busy_q;

   // Next-state, datapath and strobe computation; strobes default low each cycle.
   always_comb begin
      sync_d    = {sync_q[0], uart_rx};
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      sh_d      = sh_q;
      data_d    = data_q;
      vld_d     = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_CHK_EN
      par_d     = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d     = '0;
               sh_d      = {sh_q[6:0], rx_s};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_PAR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_PAR: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
`ifdef UART_RX_PARITY_CHK_EN
               par_d   = rx_s;
`endif
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  data_d  = sh_q;
                  vld_d   = 1'b1;
`ifdef UART_RX_PARITY_CHK_EN
                  perr_d  = (^sh_q) != par_q;
`endif
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BRK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_BRK: begin
            cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; synchroniser resets to the idle-high line level.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_q    <= 2'b11;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= 3'd0;
         sh_q      <= 8'h00;
         data_q    <= 8'h00;
         vld_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_CHK_EN
         par_q     <= 1'b0;
`endif
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
`ifdef UART_RX_PARITY_CHK_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule
